// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA-style raster timing generator.
//
// A clock divider produces a one-clk pixel enable (p_tick). The horizontal
// and vertical counters advance on p_tick. hsync, vsync, video_on,
// line_start and frame_start are all registered from the next-state counter
// values, so they line up with pixel_x/pixel_y in the same clk.
//
// Ports:
//   clk          system clock; all state changes on its rising edge
//   rst          asynchronous active-high reset
//   p_tick       one-clk pixel enable
//   pixel_x/y    horizontal / vertical position counters (CW bits)
//   hsync/vsync  sync outputs; the active level is set by HSYNC_POL/VSYNC_POL
//   video_on     high inside the active display area
//   line_start   one-clk pulse in the clk where pixel_x wraps to 0
//   frame_start  one-clk pulse in the clk where both counters wrap to 0
//   frame_count  16-bit frame counter; present only with VGA_TIMING_FRAME_CNT_EN
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          p_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]   frame_count,
`endif
  output logic          frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_ACT    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] H_SS     = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] H_SE     = CW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_SS     = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] V_SE     = CW'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic          HS_ON    = (HSYNC_POL != 0);
  localparam logic          VS_ON    = (VSYNC_POL != 0);

  logic [DW-1:0] div_q, div_d;
  logic          p_tick_q, p_tick_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_count_q, frame_count_d;
`endif

  always_comb begin
    // p_tick is registered from the next divider value, so it is high in
    // exactly the clk where div_q == CLK_DIV-1; with CLK_DIV=1 it stays high.
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    p_tick_d      = (div_d == DIV_LAST);
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (p_tick_q) begin
      if (x_q == H_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end
    hsync_d    = ((x_d >= H_SS) && (x_d < H_SE)) ? HS_ON : ~HS_ON;
    vsync_d    = ((y_d >= V_SS) && (y_d < V_SE)) ? VS_ON : ~VS_ON;
    video_on_d = (x_d < H_ACT) && (y_d < V_ACT);
`ifdef VGA_TIMING_FRAME_CNT_EN
    frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      p_tick_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_count_q <= '0;
`endif
    end else begin
      div_q         <= div_d;
      p_tick_q      <= p_tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_count_q <= frame_count_d;
`endif
    end
  end

  assign p_tick      = p_tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign frame_count = frame_count_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640; active pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48; horizontal porches and sync width, in pixels.
REQ-003 Parameter V_DISPLAY, default 480; active lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33; vertical porches and sync width, in lines.
REQ-005 Parameter CLK_DIV, default 2; clk cycles per pixel (>=1).
REQ-006 Parameter HSYNC_POL / VSYNC_POL, default 0 / 0; active sync level (0 = active-low).
REQ-007 Parameter CW, default 10; counter width, SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-008 clk  in  1  system clock; all state rises on posedge clk.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 p_tick  out  1  one-clk pixel enable.
REQ-011 pixel_x  out  CW  horizontal counter, 0..H_TOTAL-1.
REQ-012 pixel_y  out  CW  vertical counter, 0..V_TOTAL-1.
REQ-013 hsync / vsync  out  1 each  registered sync outputs, polarity per parameter.
REQ-014 video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY.
REQ-015 line_start / frame_start  out  1 each  one-clk pulses.

Function
REQ-016 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined likewise; both are elaboration-time constants.
REQ-017 Divider counts 0..CLK_DIV-1 and wraps; p_tick SHALL be high for exactly the clk in which the divider equals CLK_DIV-1; with CLK_DIV=1, p_tick SHALL be constantly high outside reset.
REQ-018 pixel_x SHALL advance by 1 only on p_tick, wrapping H_TOTAL-1 -> 0.
REQ-019 pixel_y SHALL advance by 1 only on a p_tick where pixel_x=H_TOTAL-1, wrapping V_TOTAL-1 -> 0.
REQ-020 hsync, vsync and video_on SHALL be registered from next-state counter values so they align with pixel_x/pixel_y in the same cycle, glitch-free.
REQ-021 hsync SHALL be active iff H_DISPLAY+H_FRONT <= pixel_x < H_DISPLAY+H_FRONT+H_SYNC.
REQ-022 vsync SHALL be active iff V_DISPLAY+V_FRONT <= pixel_y < V_DISPLAY+V_FRONT+V_SYNC.
REQ-023 line_start SHALL pulse in the clk where pixel_x wraps to 0.
REQ-024 frame_start SHALL pulse in the clk where both counters wrap to 0; line_start SHALL also pulse in that same clk.
REQ-025 Outside p_tick cycles, counters and syncs SHALL hold.

Reset
REQ-026 Under rst: divider=0, pixel_x=0, pixel_y=0, p_tick=0, video_on=0, line_start=0, frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
REQ-027 Reset assertion mid-frame SHALL take effect immediately, independent of clk.
REQ-028 On the first clk after release, video_on=1 (position 0,0); first p_tick occurs at clk CLK_DIV.

Configuration
REQ-029 Macro VGA_TIMING_FRAME_CNT_EN defined: adds output frame_count, 16 bits, reset 0, incremented in the frame_start cycle, wrapping 65535 -> 0.
REQ-030 Macro VGA_TIMING_FRAME_CNT_EN undefined: no frame_count port and no counter logic; all other behaviour identical.

Verification
REQ-031 Defaults, release rst -> p_tick period 2 clks; hsync low 192 clks; hsync period 1600 clks; hsync falls at pixel_x=656.
REQ-032 Defaults -> vsync low 3200 clks starting at pixel_y=490; frame_start period 840000 clks; video_on high 1280 clks per active line.
REQ-033 H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, POL=1 -> p_tick constant; line 8 clks; hsync high at x=5,6; frame 48 clks; vsync high at y=4.
REQ-034 Assert rst at pixel_x=300, pixel_y=200 between clk edges -> all outputs take reset values immediately; after release, counting restarts from (0,0).
REQ-035 With VGA_TIMING_FRAME_CNT_EN defined and the small config of REQ-033 -> frame_count=3 after 3 frames; forced value 65535 -> 0 at the next frame_start.
